// File: rtl/bus_pkg.sv
// Shared types and handshake polarity constants for the system bus arbiter.
package bus_pkg;

    localparam logic ENABLE_  = 1'b0;
    localparam logic DISABLE_ = 1'b1;
    localparam logic READ     = 1'b1;
    localparam logic WRITE    = 1'b0;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_t;

endpackage

// File: rtl/bus_arbiter_rr_select.sv
// Combinational round-robin picker: first set request at or after the pointer, wrapping.
module rr_select #(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic             o_valid,
    output logic [IDX_W-1:0] o_idx
);

    localparam int SW = IDX_W + 1;

    logic [SW-1:0]    w_sum;
    logic [IDX_W-1:0] w_cand;

    always_comb begin
        // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
        o_valid = 1'b0;
        o_idx   = '0;
        w_sum   = '0;
        w_cand  = '0;
        // Scan from the farthest offset down so the nearest requester is written last and wins.
        for (int k = N - 1; k >= 0; k--) begin
            w_sum = {1'b0, i_ptr} + SW'(k);
            if (w_sum >= SW'(N)) begin
                w_sum = w_sum - SW'(N);
            end
            w_cand = w_sum[IDX_W-1:0];
            if (i_req[w_cand]) begin
                o_valid = 1'b1;
                o_idx   = w_cand;
            end
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin system bus arbiter: registered grant, owner mux, ready routing,
// fairness pre-emption and transfer timeout detection.
module bus_arbiter
    import bus_pkg::*;
#(
    parameter int N_MASTERS = 4,
    parameter int ADDR_W    = 30,
    parameter int DATA_W    = 32,
    parameter int MAX_HOLD  = 16,
    parameter int TIMEOUT   = 255
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [N_MASTERS-1:0]          m_req_,
    output logic [N_MASTERS-1:0]          m_grnt_,
    input  logic [N_MASTERS*ADDR_W-1:0]   m_addr,
    input  logic [N_MASTERS-1:0]          m_as_,
    input  logic [N_MASTERS-1:0]          m_rw,
    input  logic [N_MASTERS*DATA_W-1:0]   m_wr_data,
    output logic [N_MASTERS-1:0]          m_rdy_,
    output logic [ADDR_W-1:0]             s_addr,
    output logic                          s_as_,
    output logic                          s_rw,
    output logic [DATA_W-1:0]             s_wr_data,
    input  logic                          s_rdy_,
    output logic [$clog2(N_MASTERS)-1:0]  owner,
    output logic                          busy,
    output logic                          bus_err
);

    localparam int IDX_W  = $clog2(N_MASTERS);
    localparam int HOLD_W = $clog2(MAX_HOLD + 1);
    localparam int TMO_W  = $clog2(TIMEOUT + 1);

    arb_state_t        r_state;
    arb_state_t        w_next_state;
    logic [IDX_W-1:0]  r_owner;
    logic [IDX_W-1:0]  r_ptr;
    logic [HOLD_W-1:0] r_hold;
    logic [TMO_W-1:0]  r_tmo;

    logic [IDX_W-1:0]     w_next_owner;
    logic [IDX_W-1:0]     w_next_ptr;
    logic                 w_grant_change;
    logic [N_MASTERS-1:0] w_req;
    logic [N_MASTERS-1:0] w_others;
    logic [N_MASTERS-1:0] w_sel_req;
    logic [IDX_W-1:0]     w_sel_ptr;
    logic [IDX_W-1:0]     w_owner_inc;
    logic                 w_sel_valid;
    logic [IDX_W-1:0]     w_sel_idx;
    logic                 w_busy;
    logic                 w_release;
    logic                 w_preempt;
    logic                 w_tmo_hit;

    assign w_busy      = (r_state == ARB_GRANT);
    assign w_req       = ~m_req_;
    assign w_others    = w_req & ~(N_MASTERS'(1) << r_owner);
    assign w_owner_inc = (r_owner == IDX_W'(N_MASTERS - 1)) ? '0 : r_owner + IDX_W'(1);

    // While granted, only the other masters compete, searched from just after the owner.
    assign w_sel_req = w_busy ? w_others : w_req;
    assign w_sel_ptr = w_busy ? w_owner_inc : r_ptr;

    assign w_release = (m_req_[r_owner] == DISABLE_);
    assign w_preempt = (r_hold == HOLD_W'(MAX_HOLD)) && (|w_others) && (m_as_[r_owner] == DISABLE_);
    assign w_tmo_hit = w_busy && (r_tmo == TMO_W'(TIMEOUT));

    rr_select #(
        .N     (N_MASTERS),
        .IDX_W (IDX_W)
    ) u_rr_select (
        .i_req   (w_sel_req),
        .i_ptr   (w_sel_ptr),
        .o_valid (w_sel_valid),
        .o_idx   (w_sel_idx)
    );

    always_ff @(posedge clk or negedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
        if (!rst) begin
            r_state <= ARB_IDLE;
            r_owner <= '0;
            r_ptr   <= '0;
        end else begin
            r_state <= w_next_state;
            r_owner <= w_next_owner;
            r_ptr   <= w_next_ptr;
        end
    end

    always_comb begin
        w_next_state   = r_state;
        w_next_owner   = r_owner;
        w_next_ptr     = r_ptr;
        w_grant_change = 1'b0;
        case (r_state)
            ARB_IDLE: begin
                if (w_sel_valid) begin
                    w_next_state   = ARB_GRANT;
                    w_next_owner   = w_sel_idx;
                    w_grant_change = 1'b1;
                end
            end
            ARB_GRANT: begin
                if (w_release || w_preempt) begin
                    w_grant_change = 1'b1;
                    w_next_ptr     = w_owner_inc;
                    if (w_sel_valid) begin
                        w_next_owner = w_sel_idx;
                    end else begin
                        w_next_state = ARB_IDLE;
                    end
                end
            end
            default: w_next_state = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hold <= '0;
            r_tmo  <= '0;
        end else begin
            if (w_grant_change) begin
                r_hold <= '0;
            end else if (w_busy && (r_hold != HOLD_W'(MAX_HOLD))) begin
                r_hold <= r_hold + HOLD_W'(1);
            end

            if (w_grant_change || !w_busy || (s_rdy_ == ENABLE_) || w_tmo_hit) begin
                r_tmo <= '0;
            end else if (s_as_ == ENABLE_) begin
                r_tmo <= r_tmo + TMO_W'(1);
            end
        end
    end

    always_comb begin
        busy      = w_busy;
        owner     = r_owner;
        bus_err   = w_tmo_hit;
        m_grnt_   = '1;
        m_rdy_    = '1;
        s_addr    = '0;
        s_as_     = DISABLE_;
        s_rw      = READ;
        s_wr_data = '0;
        if (w_busy) begin
            m_grnt_[r_owner] = ENABLE_;
            // A timeout forces ready so the stuck master can finish its access.
            m_rdy_[r_owner]  = s_rdy_ & ~w_tmo_hit;
            s_addr           = m_addr[r_owner*ADDR_W +: ADDR_W];
            s_as_            = m_as_[r_owner];
            s_rw             = m_rw[r_owner];
            s_wr_data        = m_wr_data[r_owner*DATA_W +: DATA_W];
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: directed scenarios plus randomized traffic
// compared against a behavioural model of the arbitration rules.
module tb_bus_arbiter;

    localparam int N        = 4;
    localparam int AW       = 30;
    localparam int DW       = 32;
    localparam int MAX_HOLD = 16;
    localparam int TIMEOUT  = 255;

    logic            clk;
    logic            rst;
    logic [N-1:0]    m_req_;
    logic [N-1:0]    m_grnt_;
    logic [N*AW-1:0] m_addr;
    logic [N-1:0]    m_as_;
    logic [N-1:0]    m_rw;
    logic [N*DW-1:0] m_wr_data;
    logic [N-1:0]    m_rdy_;
    logic [AW-1:0]   s_addr;
    logic            s_as_;
    logic            s_rw;
    logic [DW-1:0]   s_wr_data;
    logic            s_rdy_;
    logic [1:0]      owner;
    logic            busy;
    logic            bus_err;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model: owner index (-1 = nobody), rr pointer, granted-cycle count, wait count.
    int mdl_owner;
    int mdl_ptr;
    int mdl_held;
    int mdl_wait;

    bus_arbiter #(
        .N_MASTERS (N),
        .ADDR_W    (AW),
        .DATA_W    (DW),
        .MAX_HOLD  (MAX_HOLD),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .m_req_    (m_req_),
        .m_grnt_   (m_grnt_),
        .m_addr    (m_addr),
        .m_as_     (m_as_),
        .m_rw      (m_rw),
        .m_wr_data (m_wr_data),
        .m_rdy_    (m_rdy_),
        .s_addr    (s_addr),
        .s_as_     (s_as_),
        .s_rw      (s_rw),
        .s_wr_data (s_wr_data),
        .s_rdy_    (s_rdy_),
        .owner     (owner),
        .busy      (busy),
        .bus_err   (bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        m_req_ = '1;
        m_as_  = '1;
        m_rw   = '1;
        s_rdy_ = 1'b1;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b0;
        advance();
        rst = 1'b1;
        mdl_owner = -1;
        mdl_ptr   = 0;
        mdl_held  = 0;
        mdl_wait  = 0;
    endtask

    task automatic randomize_data();
        for (int i = 0; i < N; i++) begin
            m_addr[i*AW +: AW]    = AW'($urandom);
            m_wr_data[i*DW +: DW] = $urandom;
        end
    endtask

    function automatic int first_from(input logic [N-1:0] want, input int start);
        for (int k = 0; k < N; k++) begin
            if (want[(start + k) % N]) return (start + k) % N;
        end
        return -1;
    endfunction

    // Advances the model by one clock edge using the inputs the DUT is about to sample.
    task automatic model_step();
        logic [N-1:0] want;
        logic [N-1:0] others;
        bit           timed_out;
        int           o;
        want      = ~m_req_;
        timed_out = (mdl_owner >= 0) && (mdl_wait == TIMEOUT);
        if (mdl_owner < 0) begin
            mdl_owner = first_from(want, mdl_ptr);
            mdl_held  = 0;
            mdl_wait  = 0;
        end else begin
            o         = mdl_owner;
            others    = want;
            others[o] = 1'b0;
            if (m_req_[o] || (mdl_held >= MAX_HOLD && others != '0 && m_as_[o])) begin
                mdl_ptr   = (o + 1) % N;
                mdl_owner = first_from(others, mdl_ptr);
                mdl_held  = 0;
                mdl_wait  = 0;
            end else begin
                if (mdl_held < MAX_HOLD) mdl_held++;
                if (timed_out || !s_rdy_) mdl_wait = 0;
                else if (!m_as_[o]) mdl_wait++;
            end
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b0;
        randomize_data();
        advance();
        advance();
        n_checks++;
        if ({m_grnt_, m_rdy_, s_as_, s_rw, busy, bus_err, owner} !== {4'hf, 4'hf, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0}) begin
            n_fail++;
            $display("FAIL reset_ctrl: grnt=%b rdy=%b as=%b rw=%b busy=%b err=%b owner=%0d, want 1111 1111 1 1 0 0 0",
                     m_grnt_, m_rdy_, s_as_, s_rw, busy, bus_err, owner);
        end
        n_checks++;
        if ({s_addr, s_wr_data} !== '0) begin
            n_fail++;
            $display("FAIL reset_bus: s_addr=%h s_wr_data=%h, want 0 0", s_addr, s_wr_data);
        end

        rst    = 1'b1;
        m_req_ = 4'b1110;
        m_as_  = 4'b1110;
        advance();
        n_checks++;
        if ({m_grnt_, s_as_} !== {4'b1110, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_pre_grant: grnt=%b as=%b, want 1110 0", m_grnt_, s_as_);
        end

        #3;
        rst = 1'b0;
        #1;
        n_checks++;
        if ({m_grnt_, s_as_, busy} !== {4'b1111, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_async_drop: grnt=%b as=%b busy=%b, want 1111 1 0", m_grnt_, s_as_, busy);
        end

        advance();
        rst = 1'b1;
        #1;
        n_checks++;
        if (m_grnt_ !== 4'b1111) begin
            n_fail++;
            $display("FAIL reset_release_idle: grnt=%b, want 1111", m_grnt_);
        end
        advance();
        n_checks++;
        if ({m_grnt_, owner, busy} !== {4'b1110, 2'd0, 1'b1}) begin
            n_fail++;
            $display("FAIL reset_regrant: grnt=%b owner=%0d busy=%b, want 1110 0 1", m_grnt_, owner, busy);
        end
        idle_inputs();
        advance();
    endtask

    task automatic test_simultaneous();
        logic [N-1:0] exp_g;
        int           want;
        do_reset();
        m_req_ = '0;
        advance();
        for (int k = 0; k < 10; k++) begin
            want        = (k / 2) % N;
            exp_g       = '1;
            exp_g[want] = 1'b0;
            #1;
            n_checks++;
            if ({m_grnt_, busy, owner} !== {exp_g, 1'b1, 2'(want)}) begin
                n_fail++;
                $display("FAIL simul_order[%0d]: grnt=%b busy=%b owner=%0d, want %b 1 %0d",
                         k, m_grnt_, busy, owner, exp_g, want);
            end
            m_req_ = '0;
            if ((k % 2) == 1) m_req_[want] = 1'b1;
            advance();
        end
        idle_inputs();
        advance();
    endtask

    task automatic test_hold_release();
        m_req_ = 4'b1011;
        advance();
        for (int k = 0; k < 40; k++) begin
            randomize_data();
            m_rw = 4'($urandom);
            #1;
            n_checks++;
            if ({m_grnt_, busy, owner} !== {4'b1011, 1'b1, 2'd2}) begin
                n_fail++;
                $display("FAIL hold_grant[%0d]: grnt=%b busy=%b owner=%0d, want 1011 1 2", k, m_grnt_, busy, owner);
            end
            n_checks++;
            if ({s_addr, s_rw} !== {m_addr[2*AW +: AW], m_rw[2]}) begin
                n_fail++;
                $display("FAIL hold_mux[%0d]: s_addr=%h rw=%b, want %h %b", k, s_addr, s_rw, m_addr[2*AW +: AW], m_rw[2]);
            end
            if (k == 39) m_req_ = '1;
            advance();
        end
        n_checks++;
        if ({m_grnt_, busy, s_as_, s_rw} !== {4'b1111, 1'b0, 1'b1, 1'b1}) begin
            n_fail++;
            $display("FAIL hold_release_idle: grnt=%b busy=%b as=%b rw=%b, want 1111 0 1 1", m_grnt_, busy, s_as_, s_rw);
        end
        idle_inputs();
    endtask

    task automatic test_preempt();
        do_reset();
        m_req_ = 4'b1110;
        advance();
        for (int c = 0; c <= MAX_HOLD; c++) begin
            if (c == 5) m_req_[3] = 1'b0;
            #1;
            n_checks++;
            if (m_grnt_ !== 4'b1110) begin
                n_fail++;
                $display("FAIL preempt_hold[%0d]: grnt=%b, want 1110", c, m_grnt_);
            end
            advance();
        end
        n_checks++;
        if ({m_grnt_, owner} !== {4'b0111, 2'd3}) begin
            n_fail++;
            $display("FAIL preempt_move: grnt=%b owner=%0d, want 0111 3", m_grnt_, owner);
        end

        do_reset();
        m_req_ = 4'b0110;
        m_as_  = 4'b1110;
        advance();
        for (int c = 0; c < 30; c++) begin
            #1;
            n_checks++;
            if (m_grnt_ !== 4'b1110) begin
                n_fail++;
                $display("FAIL preempt_blocked[%0d]: grnt=%b, want 1110", c, m_grnt_);
            end
            advance();
        end
        m_as_ = '1;
        advance();
        n_checks++;
        if ({m_grnt_, owner} !== {4'b0111, 2'd3}) begin
            n_fail++;
            $display("FAIL preempt_after_strobe: grnt=%b owner=%0d, want 0111 3", m_grnt_, owner);
        end
        idle_inputs();
        advance();
    endtask

    task automatic test_routing();
        logic [N-1:0] exp_r;
        do_reset();
        randomize_data();
        m_addr[1*AW +: AW] = 30'h100;
        m_req_ = 4'b1101;
        m_as_  = 4'b1101;
        advance();
        for (int k = 0; k < 6; k++) begin
            s_rdy_ = (k == 3) ? 1'b0 : 1'b1;
            exp_r  = (k == 3) ? 4'b1101 : 4'b1111;
            #1;
            n_checks++;
            if ({s_addr, s_as_, s_rw} !== {30'h100, 1'b0, 1'b1}) begin
                n_fail++;
                $display("FAIL route_bus[%0d]: s_addr=%h as=%b rw=%b, want 100 0 1", k, s_addr, s_as_, s_rw);
            end
            n_checks++;
            if (m_rdy_ !== exp_r) begin
                n_fail++;
                $display("FAIL route_rdy[%0d]: m_rdy_=%b, want %b", k, m_rdy_, exp_r);
            end
            advance();
        end
        m_rw[1] = 1'b0;
        #1;
        n_checks++;
        if ({s_rw, s_wr_data} !== {1'b0, m_wr_data[1*DW +: DW]}) begin
            n_fail++;
            $display("FAIL route_write: rw=%b wdata=%h, want 0 %h", s_rw, s_wr_data, m_wr_data[1*DW +: DW]);
        end
        idle_inputs();
        advance();
    endtask

    task automatic test_timeout();
        logic         exp_e;
        logic [N-1:0] exp_r;
        do_reset();
        m_req_ = 4'b1011;
        m_as_  = 4'b1011;
        advance();
        // Cycle 0 is the first cycle with the strobe on the bus.
        for (int c = 0; c < 2 * (TIMEOUT + 1) + 8; c++) begin
            exp_e = ((c % (TIMEOUT + 1)) == TIMEOUT);
            exp_r = exp_e ? 4'b1011 : 4'b1111;
            #1;
            n_checks++;
            if ({bus_err, m_rdy_} !== {exp_e, exp_r}) begin
                n_fail++;
                $display("FAIL timeout[%0d]: bus_err=%b m_rdy_=%b, want %b %b", c, bus_err, m_rdy_, exp_e, exp_r);
            end
            advance();
        end
        idle_inputs();
        advance();
    endtask

    task automatic test_random();
        logic [N-1:0]  exp_g;
        logic [N-1:0]  exp_r;
        logic [AW-1:0] exp_a;
        logic [DW-1:0] exp_d;
        logic          exp_as;
        logic          exp_rw;
        logic          exp_e;
        do_reset();
        for (int cyc = 0; cyc < 2000; cyc++) begin
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 15) == 0) m_req_[i] = ~m_req_[i];
            end
            m_as_  = 4'($urandom);
            m_rw   = 4'($urandom);
            s_rdy_ = ($urandom_range(0, 3) != 0);
            randomize_data();

            exp_g  = '1;
            exp_r  = '1;
            exp_a  = '0;
            exp_d  = '0;
            exp_as = 1'b1;
            exp_rw = 1'b1;
            exp_e  = 1'b0;
            if (mdl_owner >= 0) begin
                exp_e            = (mdl_wait == TIMEOUT);
                exp_g[mdl_owner] = 1'b0;
                exp_r[mdl_owner] = s_rdy_ & ~exp_e;
                exp_a            = m_addr[mdl_owner*AW +: AW];
                exp_d            = m_wr_data[mdl_owner*DW +: DW];
                exp_as           = m_as_[mdl_owner];
                exp_rw           = m_rw[mdl_owner];
            end
            #1;
            n_checks++;
            if ({m_grnt_, busy, bus_err} !== {exp_g, mdl_owner >= 0, exp_e}) begin
                n_fail++;
                $display("FAIL rand_grant[%0d]: grnt=%b busy=%b err=%b, want %b %b %b",
                         cyc, m_grnt_, busy, bus_err, exp_g, mdl_owner >= 0, exp_e);
            end
            n_checks++;
            if (m_rdy_ !== exp_r) begin
                n_fail++;
                $display("FAIL rand_rdy[%0d]: m_rdy_=%b, want %b", cyc, m_rdy_, exp_r);
            end
            n_checks++;
            if ({s_addr, s_as_, s_rw, s_wr_data} !== {exp_a, exp_as, exp_rw, exp_d}) begin
                n_fail++;
                $display("FAIL rand_mux[%0d]: addr=%h as=%b rw=%b wdata=%h, want %h %b %b %h",
                         cyc, s_addr, s_as_, s_rw, s_wr_data, exp_a, exp_as, exp_rw, exp_d);
            end
            if (mdl_owner >= 0) begin
                n_checks++;
                if (owner !== 2'(mdl_owner)) begin
                    n_fail++;
                    $display("FAIL rand_owner[%0d]: owner=%0d, want %0d", cyc, owner, mdl_owner);
                end
            end
            model_step();
            advance();
        end
        idle_inputs();
        advance();
    endtask

    initial begin
        m_addr    = '0;
        m_wr_data = '0;
        test_reset();
        test_simultaneous();
        test_hold_release();
        test_preempt();
        test_routing();
        test_timeout();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Shares the single system bus between up to N bus masters, e.g. the IF-stage bus_if, the MEM-stage bus_if and a DMA/debug port.
- Each master drives the active-low req_/grnt_/rdy_ handshake of the bus_io master modport.
- Round-robin arbitration, registered grant, and multiplexing of the owner's address/control/write data onto the slave side.
- Routes rdy_ only to the owner, enforces a fairness hold limit and flags hung transfers.

Parameters:
- N_MASTERS, 4, number of requesters (2..8).
- ADDR_W, 30, word address width (`WordAddr).
- DATA_W, 32, data width (`WordData).
- MAX_HOLD, 16, grant cycles after which an idle owner is pre-empted if others are waiting.
- TIMEOUT, 255, max cycles from s_as_ low to s_rdy_ low before bus_err.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous active-low reset.
- m_req_  in  N_MASTERS  per-master request, active low.
- m_grnt_  out  N_MASTERS  per-master grant, active low, one-hot-low or all high.
- m_addr  in  N_MASTERS*ADDR_W  per-master word address.
- m_as_  in  N_MASTERS  per-master address strobe, active low.
- m_rw  in  N_MASTERS  per-master `READ/`WRITE.
- m_wr_data  in  N_MASTERS*DATA_W  per-master write data.
- m_rdy_  out  N_MASTERS  ready routed to owner only, active low.
- s_addr  out  ADDR_W  muxed address to slaves.
- s_as_  out  1  muxed strobe; high when no owner.
- s_rw  out  1  muxed rw; `READ when no owner.
- s_wr_data  out  DATA_W  muxed write data; 0 when no owner.
- s_rdy_  in  1  slave ready, active low.
- owner  out  $clog2(N_MASTERS)  current owner index (valid when busy).
- busy  out  1  a grant is active.
- bus_err  out  1  one-cycle pulse on transfer timeout.

Behaviour:
- Reset (rst low, async):
  - all m_grnt_ and m_rdy_ high; s_as_ high, s_rw `READ, s_addr 0, s_wr_data 0.
  - owner 0, busy 0, bus_err 0; rr pointer 0; hold and timeout counters 0.
  - Reset asserted mid-transfer drops the grant immediately; no completion is signalled.
- FSM states:
  - IDLE: no grant.
  - GRANT: owner holds the bus.
- IDLE -> GRANT: any m_req_ low at a clock edge. Winner = first requester at or after rr pointer, wrapping. Its m_grnt_ goes low the next cycle (1-cycle latency).
- GRANT, owner keeps m_req_ low: grant held. Hold counter increments, saturating at MAX_HOLD.
- GRANT, owner releases (m_req_ high at an edge):
  - if other requests are pending, the grant moves directly to the next requester after owner (wrap), with no idle bubble;
  - else -> IDLE.
  - rr pointer = old owner + 1 mod N.
- Pre-emption: hold counter == MAX_HOLD, another request pending, and owner m_as_ high (no access in flight) -> grant passes as on a release. The owner sees m_grnt_ high and must re-request.
- Mux: s_* combinationally follow owner while busy; idle values otherwise.
- m_rdy_[owner] = s_rdy_ while busy; all other m_rdy_ stay high.
- Timeout counter:
  - counts while busy, s_as_ low and s_rdy_ high;
  - clears on s_rdy_ low or grant change;
  - at TIMEOUT: bus_err pulses 1 cycle, m_rdy_[owner] is forced low that cycle to release the master, and the counter clears.
- Simultaneous requests in IDLE: the rr pointer decides; pointer 0 means lowest index wins.
- Grant change clears the hold counter.

Decomposition:
- Shared package bus_pkg:
  - arb_state_t enum {ARB_IDLE, ARB_GRANT};
  - localparams for `ENABLE_/`DISABLE_ and `READ/`WRITE, re-exported from stddef.vh.
- One sub-module, rr_select: combinational round-robin picker.
  - Inputs: request vector (active-high internally), pointer.
  - Outputs: valid, index.
- FSM, counters and mux live in bus_arbiter.

Test Plan:
- Reset: rst low mid-grant with m_req_=4'b1110 -> same cycle all m_grnt_=4'b1111, s_as_=1; after release with m_req_ held, grant to master 0 one cycle later.
- Simultaneous: m_req_=4'b0000 from IDLE, each master releases after 2 cycles -> grant order 0,1,2,3,0 with no idle cycles between owners.
- Hold/release: master 2 alone requests for 40 cycles -> m_grnt_=4'b1011 for all 40; busy=1; owner=2; after release, IDLE next cycle.
- Pre-emption: master 0 holds with m_as_ high, master 3 requests at cycle 5 -> m_grnt_ moves to master 3 exactly after hold reaches 16; no pre-emption while master 0 m_as_ is low.
- Routing: owner 1 issues read of addr 30'h100; slave drives s_rdy_ low after 3 cycles -> s_addr=30'h100, m_rdy_=4'b1101 that cycle only.
- Timeout: owner strobes, s_rdy_ never low -> bus_err pulses at cycle 255 after s_as_ low, m_rdy_[owner] low for 1 cycle, counter restarts.
